// File: rtl/toy_pack.sv
// Shared toy-bus types and widths, plus the timer register offset map.
// Included first so every block that talks to the toy bus agrees on encodings.
package toy_pack;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned BUS_DATA_WIDTH = 32;

    typedef enum logic {
        TOY_BUS_READ  = 1'b0,
        TOY_BUS_WRITE = 1'b1
    } toy_bus_op_t;

    // Word offsets decoded from addr[4:2]; 5..7 are unmapped.
    typedef enum logic [2:0] {
        MSIP        = 3'd0,
        MTIMECMP_LO = 3'd1,
        MTIMECMP_HI = 3'd2,
        MTIME_LO    = 3'd3,
        MTIME_HI    = 3'd4
    } timer_reg_t;

    typedef enum logic {
        StIdle,
        StResp
    } timer_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/toy_timer_slave.sv
// CLINT-style machine timer on the toy request/ack bus: 64-bit mtime with a
// prescaler, 64-bit mtimecmp, msip bit, registered mtip comparison.
module toy_timer_slave
    import toy_pack::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic                      req_op,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]                req_strb,
    output logic                      ack_vld,
    input  logic                      ack_rdy,
    output logic [BUS_DATA_WIDTH-1:0] ack_rdata,
    output logic                      ack_err,
    output logic                      mtip,
    output logic                      msip
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    timer_state_e               state_q, state_d;
    logic [15:0]                presc_q, presc_d;
    logic [63:0]                mtime_q, mtime_d;
    logic [63:0]                cmp_q, cmp_d;
    logic                       msip_q, msip_d;
    logic                       mtip_q, mtip_d;
    logic [BUS_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                       err_q, err_d;

    logic                       tick;
    logic                       accept;
    logic                       is_write;
    logic                       mapped;
    timer_reg_t                 reg_off;
    logic [31:0]                reg_rdata;
    logic                       unused_addr;

    assign unused_addr = ^{req_addr[ADDR_WIDTH-1:5], req_addr[1:0]};

    assign reg_off  = timer_reg_t'(req_addr[4:2]);
    assign mapped   = (req_addr[4:2] <= 3'd4);
    assign is_write = (req_op == TOY_BUS_WRITE);
    assign accept   = (state_q == StIdle) && req_vld;
    assign tick     = (presc_q == PRESC_MAX);

    // Gated by rst_n so the initiator never sees ready while reset is held.
    assign req_rdy   = (state_q == StIdle) && rst_n;
    assign ack_vld   = (state_q == StResp);
    assign ack_rdata = rdata_q;
    assign ack_err   = err_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            MSIP:        reg_rdata = {31'b0, msip_q};
            MTIMECMP_LO: reg_rdata = cmp_q[31:0];
            MTIMECMP_HI: reg_rdata = cmp_q[63:32];
            MTIME_LO:    reg_rdata = mtime_q[31:0];
            MTIME_HI:    reg_rdata = mtime_q[63:32];
            default:     reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mtip_d  = (mtime_q >= cmp_q);

        unique case (state_q)
            StIdle: if (req_vld) state_d = StResp;
            StResp: if (ack_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            err_d   = !mapped;
            rdata_d = (!is_write && mapped) ? reg_rdata : '0;
            if (is_write && mapped) begin
                case (reg_off)
                    MSIP: if (req_strb[0]) msip_d = req_wdata[0];
                    MTIMECMP_LO: cmp_d[31:0]  = apply_strb(cmp_q[31:0], req_wdata, req_strb);
                    MTIMECMP_HI: cmp_d[63:32] = apply_strb(cmp_q[63:32], req_wdata, req_strb);
                    // A real mtime write overrides the tick; the other half keeps its old value.
                    MTIME_LO: if (|req_strb) begin
                        mtime_d = {mtime_q[63:32],
                                   apply_strb(mtime_q[31:0], req_wdata, req_strb)};
                    end
                    MTIME_HI: if (|req_strb) begin
                        mtime_d = {apply_strb(mtime_q[63:32], req_wdata, req_strb),
                                   mtime_q[31:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= CMP_RST;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/toy_timer_slave.md
TOY_TIMER_SLAVE -- requirements
Module: toy_timer_slave

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, giving clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have parameter CMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of mtimecmp.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_vld  input  1  initiator request valid.
REQ-006 SHALL have port req_rdy  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_op  input  1  toy_bus_op_t; TOY_BUS_READ=0, TOY_BUS_WRITE=1.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address; only [4:2] decoded.
REQ-009 SHALL have port req_wdata  input  BUS_DATA_WIDTH  write data.
REQ-010 SHALL have port req_strb  input  4  byte write enables.
REQ-011 SHALL have port ack_vld  output  1  response valid.
REQ-012 SHALL have port ack_rdy  input  1  initiator accepts the response.
REQ-013 SHALL have port ack_rdata  output  BUS_DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port ack_err  output  1  access hit an unmapped offset.
REQ-015 SHALL have port mtip  output  1  machine timer interrupt pending (mip.mtip source).
REQ-016 SHALL have port msip  output  1  machine software interrupt pending (mip.msip source).

Function
REQ-017 SHALL map addr[4:2]: 0=msip (bit0 only, rest read 0), 1=mtimecmp[31:0], 2=mtimecmp[63:32], 3=mtime[31:0], 4=mtime[63:32]; 5..7 unmapped.
REQ-018 SHALL implement FSM IDLE/RESP: IDLE drives req_rdy=1, ack_vld=0; req_vld in IDLE accepts the request and moves to RESP.
REQ-019 SHALL drive ack_vld=1, req_rdy=0 in RESP, hold ack_rdata/ack_err stable until ack_rdy, then return to IDLE; at most one outstanding request, accept-to-ack latency exactly 1 cycle.
REQ-020 SHALL capture read data from the register value in the accept cycle (pre-tick, pre-write).
REQ-021 SHALL apply writes in the accept cycle per req_strb byte lanes; req_strb=0 is a legal no-op write.
REQ-022 SHALL make unmapped accesses return ack_err=1, ack_rdata=0, and modify no state.
REQ-023 SHALL keep a prescaler counting 0..TICK_DIV-1 and increment 64-bit mtime by 1 on wrap; mtime wraps 2^64-1 -> 0.
REQ-024 SHALL give a bus write to either mtime half priority over the tick in the same cycle; the other half keeps its pre-write value (no carry); the prescaler is not reset.
REQ-025 SHALL register mtip = (mtime >= mtimecmp), unsigned 64-bit, updated every cycle (1-cycle lag after mtime/mtimecmp change).
REQ-026 SHALL drive msip directly from the msip register bit.
REQ-027 SHALL ignore req_vld while in RESP (req_rdy=0); the initiator holds the request.

Reset
REQ-028 SHALL on rst_n=0 asynchronously set: FSM=IDLE, req_rdy=0 during reset then 1 after, ack_vld=0, ack_rdata=0, ack_err=0, mtime=0, prescaler=0, mtimecmp=CMP_RST, msip=0, mtip=0.
REQ-029 SHALL drop a pending response on reset mid-transaction without emitting ack_vld afterwards.

Structure
REQ-030 SHALL take toy_bus_op_t, ADDR_WIDTH, BUS_DATA_WIDTH from toy_pack; new offset enum timer_reg_t (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI) SHALL be added to toy_pack.
REQ-031 SHALL be a single module; no sub-module required.

Verification
REQ-032 Reset, idle 10 cycles, read offset 0x0C with TICK_DIV=1 -> ack_rdata=32'd10 (+/-1 per accept cycle), ack_err=0, mtip=0.
REQ-033 Write mtimecmp_lo=0x20, mtimecmp_hi=0 -> mtip rises exactly one cycle after mtime reaches 0x20, stays 1.
REQ-034 Write mtime_lo=0xFFFFFFFF, mtime_hi=0, TICK_DIV=1 -> two cycles later read mtime_hi=1, mtime_lo small.
REQ-035 Write 0x0000ABCD to 0x0C with strb=4'b0011 while tick fires -> mtime_lo[15:0]=0xABCD, no increment that cycle.
REQ-036 Read 0x18 -> ack_err=1, ack_rdata=0; write 1 to 0x00 -> msip=1; hold ack_rdy=0 5 cycles -> ack_vld, data stable, req_rdy=0.
REQ-037 Assert rst_n=0 while ack_vld=1 -> ack_vld=0 immediately, mtimecmp=CMP_RST, no further ack.
